// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared types and constants for the PWM capture block.
// Holds the measurement FSM state encoding and the default counter width.
package pwm_pkg;

  // Default width of the cycle counter and the period/high_time outputs.
  localparam int PWM_WIDTH_DEFAULT = 16;

  // Measurement FSM states.
  //   IDLE : no session
  //   ARM  : waiting for the first rising edge
  //   HIGH : counting, pwm_in currently high
  //   LOW  : counting, pwm_in currently low
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } pwm_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if -- control, waveform and measurement signals of pwm_capture.
// master: the controller/environment side; slave: the capture block itself.
interface pwm_capture_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             stop;
  logic             pwm_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             busy;
  logic             overflow;

  modport master (
    output start, stop, pwm_in,
    input  period, high_time, valid, busy, overflow
  );

  modport slave (
    input  start, stop, pwm_in,
    output period, high_time, valid, busy, overflow
  );

endinterface

// File: rtl/pwm_sync_filter.sv
// pwm_sync_filter -- brings the asynchronous pwm_in into the clock domain
// and produces the level (lvl) used for edge detection.
// With PWM_CAPTURE_FILTER_EN defined, lvl only follows the synchronized
// input after three consecutive identical samples (2 extra cycles latency,
// pulses shorter than 3 cycles are dropped). Without it, lvl is the raw
// synchronizer output. SYNC_STAGES must be at least 2.
module pwm_sync_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic lvl
);

  logic [SYNC_STAGES-1:0] sync_reg;

  // Synchronizer chain: pwm_in enters at bit 0, the settled level leaves at the top bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic       sync_lvl;
  logic [1:0] hist_reg;
  logic       lvl_reg;
  logic       agree;

  assign sync_lvl = sync_reg[SYNC_STAGES-1];
  // Current sample plus the two previous ones must all match before lvl moves;
  // otherwise the last accepted level is held. Same delay for both edges.
  assign agree    = (sync_lvl == hist_reg[0]) && (sync_lvl == hist_reg[1]);
  assign lvl      = agree ? sync_lvl : lvl_reg;

  // Sample history and the held level for the deglitch filter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hist_reg <= '0;
      lvl_reg  <= 1'b0;
    end else begin
      hist_reg <= {hist_reg[0], sync_lvl};
      lvl_reg  <= lvl;
    end
  end
`else
  assign lvl = sync_reg[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture -- measures period and high time of an asynchronous PWM input
// in clock cycles. After start, every rising edge from the second one onward
// produces a one-cycle valid pulse with fresh period/high_time values.
// Counter saturation without a closing edge sets a sticky overflow flag and
// re-arms. Optional deglitch filter: PWM_CAPTURE_FILTER_EN (in pwm_sync_filter).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input logic         clock,
  input logic         reset,
  pwm_capture_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  pwm_state_t       state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic [WIDTH-1:0] high_time_reg, high_time_next;
  logic             valid_reg, valid_next;
  logic             overflow_reg, overflow_next;
  logic             lvl;
  logic             lvl_prev_reg;
  logic             rise;
  logic             fall;

  pwm_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_filter (
    .clock  (clock),
    .reset  (reset),
    .pwm_in (bus.pwm_in),
    .lvl    (lvl)
  );

  assign rise = lvl & ~lvl_prev_reg;
  assign fall = ~lvl & lvl_prev_reg;

  // State, counter, measurement registers and the edge-detect history.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hi_reg        <= '0;
      period_reg    <= '0;
      high_time_reg <= '0;
      valid_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      lvl_prev_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hi_reg        <= hi_next;
      period_reg    <= period_next;
      high_time_reg <= high_time_next;
      valid_reg     <= valid_next;
      overflow_reg  <= overflow_next;
      lvl_prev_reg  <= lvl;
    end
  end

  // Next-state and datapath decisions; stop out-ranks edges and start.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hi_next        = hi_reg;
    period_next    = period_reg;
    high_time_next = high_time_reg;
    valid_next     = 1'b0;
    overflow_next  = overflow_reg;

    if ((state_reg != IDLE) && bus.stop) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_next    = ARM;
            overflow_next = 1'b0;
          end
        end
        ARM: begin
          // Falling edges are irrelevant until the first rising edge.
          if (rise) begin
            state_next = HIGH;
            cnt_next   = CNT_ONE;
          end
        end
        HIGH: begin
          // A saturated counter cannot hold a valid period any more, so a
          // falling edge arriving exactly at saturation is also treated as overflow.
          if (cnt_reg == CNT_MAX) begin
            state_next    = ARM;
            overflow_next = 1'b1;
          end else if (fall) begin
            hi_next    = cnt_reg;
            cnt_next   = cnt_reg + CNT_ONE;
            state_next = LOW;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        LOW: begin
          if (rise) begin
            period_next    = cnt_reg;
            high_time_next = hi_reg;
            valid_next     = 1'b1;
            cnt_next       = CNT_ONE;
            state_next     = HIGH;
          end else if (cnt_reg == CNT_MAX) begin
            state_next    = ARM;
            overflow_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.period    = period_reg;
  assign bus.high_time = high_time_reg;
  assign bus.valid     = valid_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter WIDTH, default 16, bit width of the cycle counter and the measurement outputs.
REQ-002 Parameter SYNC_STAGES, default 2, number of flops in the pwm_in synchronizer (minimum 2).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 start  input  1  level; in IDLE, arms a measurement session.
REQ-006 stop  input  1  level; from any state, ends the session.
REQ-007 pwm_in  input  1  asynchronous PWM waveform to be measured.
REQ-008 period  output  WIDTH  clock cycles between the last two rising edges.
REQ-009 high_time  output  WIDTH  clock cycles pwm_in was high within that period.
REQ-010 valid  output  1  one-cycle pulse; period/high_time updated this cycle.
REQ-011 busy  output  1  high in ARM, HIGH and LOW.
REQ-012 overflow  output  1  sticky; counter saturated with no closing edge.

Function
REQ-013 pwm_in SHALL pass through SYNC_STAGES flops; edges SHALL be detected by comparing the synchronized level (lvl) with its previous-cycle value.
REQ-014 States SHALL be IDLE, ARM, HIGH and LOW; cnt is a WIDTH-bit register.
REQ-015 IDLE: start=1 and stop=0 -> ARM, overflow<=0; otherwise remain in IDLE.
REQ-016 ARM: ignore falling edges; a rising edge -> HIGH with cnt<=1.
REQ-017 HIGH: each cycle cnt<=cnt+1; a falling edge -> hi<=cnt (internal), cnt<=cnt+1, LOW.
REQ-018 LOW: each cycle cnt<=cnt+1; a rising edge -> period<=cnt, high_time<=hi, valid<=1, cnt<=1, HIGH.
REQ-019 Measurement is continuous: every subsequent rising edge produces a new valid pulse with no re-arm.
REQ-020 valid SHALL assert the cycle after the edge is detected and deassert one cycle later.
REQ-021 In HIGH or LOW, reaching cnt all-ones without the closing edge -> overflow<=1, ARM; period and high_time unchanged; no valid.
REQ-022 stop=1 in any non-IDLE state -> IDLE next cycle; stop overrides a simultaneous edge or start; no valid pulse.
REQ-023 start while busy SHALL be ignored.
REQ-024 period and high_time SHALL hold their last values through IDLE, stop, and overflow.
REQ-025 A fixed pin-to-detection latency of SYNC_STAGES+1 cycles applies equally to both edges, so it does not bias the measurements.

Reset
REQ-026 reset=0 at a clock edge -> IDLE; cnt, hi, period and high_time <=0; valid, busy and overflow <=0; synchronizer flops <=0.
REQ-027 Reset mid-measurement SHALL discard the partial count; no valid pulse follows.

Configuration
REQ-028 Macro PWM_CAPTURE_FILTER_EN defined -> lvl changes only after 3 consecutive identical synchronized samples; adds 2 cycles latency; pulses under 3 cycles are ignored.
REQ-029 Macro PWM_CAPTURE_FILTER_EN undefined -> lvl is the raw synchronizer output; no filter logic is present.

Structure
REQ-030 Package pwm_pkg SHALL hold the state enum typedef (IDLE/ARM/HIGH/LOW) and the default WIDTH constant.
REQ-031 Sub-module pwm_sync_filter SHALL hold the synchronizer and the optional filter and output lvl; the FSM, counter and output registers stay in pwm_capture.

Verification
REQ-032 Stimulus: WIDTH=16, start pulse, pwm_in 3 high / 5 low, repeated 4 times. Required: valid pulses after each rising edge from the second onward, with period=8 and high_time=3.
REQ-033 Stimulus: pwm_in held constant high after arming, WIDTH=8. Required: overflow=1 after 255 counted cycles, state returns to ARM, no valid pulse.
REQ-034 Stimulus: stop asserted in the same cycle as a closing rising edge. Required: no valid pulse, busy=0 next cycle, period unchanged.
REQ-035 Stimulus: reset=0 for 1 cycle mid-LOW. Required: all outputs read 0 next cycle, state IDLE, and start is needed to resume.
REQ-036 Stimulus: build with PWM_CAPTURE_FILTER_EN, 1-cycle glitch low inside a 10-cycle high pulse of a 10/10 waveform. Required: period=20, high_time=10.
REQ-037 Stimulus: start while busy. Required: ignored. Stimulus: start after overflow. Required: overflow cleared to 0 on entry to ARM.
